rx_packet_capture: RTL and testbench

RX_PACKET_CAPTURE -- requirements
Module: rx_packet_capture

---
 rtl/rx_packet_capture.sv | 195 +++++++++++++++++++
 tb/tb_rx_packet_capture.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_capture.sv
// rx_packet_capture: captures one Ethernet packet streamed as 16-bit words,
// stages the MAC header fields, and publishes them only when the packet
// length is legal. Handshake: ethernet_rcv_req_out is high exactly while in
// RECV; a word is taken on every RECV cycle with ethernet_rcv_data_rdy_in=1,
// and ethernet_rcv_complete_in=1 ends the packet (a word in that same cycle
// is still taken). No back-pressure is applied to the controller.
module rx_packet_capture #(
    parameter logic [47:0] MY_MAC    = 48'h0123_4567_89AB,
    parameter logic [15:0] TIMEOUT   = 16'd50000,
    parameter logic [10:0] MAX_WORDS = 11'd760
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start_rx,
    output logic        ethernet_rcv_req_out,
    input  logic [15:0] ethernet_rcv_data_in,
    input  logic        ethernet_rcv_data_rdy_in,
    input  logic        ethernet_rcv_complete_in,
    output logic [47:0] rx_dest_mac,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_ethertype,
    output logic [10:0] rx_word_count,
    output logic        rx_packet_valid,
    output logic        rx_error,
    output logic        rx_addr_match,
    output logic [15:0] rx_packet_count,
    output logic [8:0]  Debug_LEDG,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [10:0] MIN_WORDS = 11'd7;
    localparam logic [10:0] CNT_SAT   = 11'h7FF;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [10:0] word_cnt_q, word_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [47:0] stg_dest_q, stg_dest_d;
    logic [47:0] stg_src_q, stg_src_d;
    logic [15:0] stg_type_q, stg_type_d;
    logic [47:0] dest_q, dest_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [10:0] wc_q, wc_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        match_q, match_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] word_swapped;

    // Byte order on the wire puts the low byte of each word first.
    assign word_swapped = {ethernet_rcv_data_in[7:0], ethernet_rcv_data_in[15:8]};

    // Next-state, capture and publish logic. The length check runs on the
    // RECV->DONE edge using next-cycle staging values, so a word arriving with
    // complete is included and the pulse is visible during the DONE cycle.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        idle_cnt_d = idle_cnt_q;
        stg_dest_d = stg_dest_q;
        stg_src_d  = stg_src_q;
        stg_type_d = stg_type_q;
        dest_d     = dest_q;
        src_d      = src_q;
        type_d     = type_q;
        wc_d       = wc_q;
        match_d    = match_q;
        pkt_cnt_d  = pkt_cnt_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_rx) begin
                    state_d    = S_RECV;
                    word_cnt_d = '0;
                    idle_cnt_d = '0;
                    stg_dest_d = '0;
                    stg_src_d  = '0;
                    stg_type_d = '0;
                end
            end
            S_RECV: begin
                if (ethernet_rcv_data_rdy_in) begin
                    idle_cnt_d = '0;
                    case (word_cnt_q)
                        11'd0:   stg_dest_d[47:32] = word_swapped;
                        11'd1:   stg_dest_d[31:16] = word_swapped;
                        11'd2:   stg_dest_d[15:0]  = word_swapped;
                        11'd3:   stg_src_d[47:32]  = word_swapped;
                        11'd4:   stg_src_d[31:16]  = word_swapped;
                        11'd5:   stg_src_d[15:0]   = word_swapped;
                        11'd6:   stg_type_d        = word_swapped;
                        default: ;
                    endcase
                    if (word_cnt_q != CNT_SAT) begin
                        word_cnt_d = word_cnt_q + 11'd1;
                    end
                end

                if (ethernet_rcv_complete_in) begin
                    state_d = S_DONE;
                    if ((word_cnt_d >= MIN_WORDS) && (word_cnt_d <= MAX_WORDS)) begin
                        dest_d    = stg_dest_d;
                        src_d     = stg_src_d;
                        type_d    = stg_type_d;
                        wc_d      = word_cnt_d;
                        valid_d   = 1'b1;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        match_d   = (stg_dest_d == MY_MAC) || (stg_dest_d == 48'hFFFF_FFFF_FFFF);
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (!ethernet_rcv_data_rdy_in) begin
                    // Abort once TIMEOUT consecutive silent cycles have elapsed.
                    if ((idle_cnt_q + 16'd1) == TIMEOUT) begin
                        error_d    = 1'b1;
                        state_d    = S_IDLE;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request is registered and tracks the RECV state exactly.
    always_comb begin
        req_d = (state_d == S_RECV);
    end

    // State and output registers; reset discards any packet in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            stg_dest_q <= '0;
            stg_src_q  <= '0;
            stg_type_q <= '0;
            dest_q     <= '0;
            src_q      <= '0;
            type_q     <= '0;
            wc_q       <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            match_q    <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            word_cnt_q <= word_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            stg_dest_q <= stg_dest_d;
            stg_src_q  <= stg_src_d;
            stg_type_q <= stg_type_d;
            dest_q     <= dest_d;
            src_q      <= src_d;
            type_q     <= type_d;
            wc_q       <= wc_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            match_q    <= match_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign ethernet_rcv_req_out = req_q;
    assign rx_dest_mac          = dest_q;
    assign rx_src_mac           = src_q;
    assign rx_ethertype         = type_q;
    assign rx_word_count        = wc_q;
    assign rx_packet_valid      = valid_q;
    assign rx_error             = error_q;
    assign rx_addr_match        = match_q;
    assign rx_packet_count      = pkt_cnt_q;
    assign Debug_LEDG           = {req_q, pkt_cnt_q[7:0]};
    assign state_dbg            = state_q;

endmodule

// File: tb/tb_rx_packet_capture.sv
// Bench for rx_packet_capture: table of packets plus hand-written timeout and
// reset sequences; expected publish/error events flow through exp_q.
module tb_rx_packet_capture;

    localparam logic [47:0] MY_MAC  = 48'h0123_4567_89AB;
    localparam int          TIMEOUT = 50000;
    localparam int          MAX_W   = 760;
    localparam int          W       = 141;

    logic        Clock;
    logic        Reset;
    logic        start_rx;
    logic        ethernet_rcv_req_out;
    logic [15:0] ethernet_rcv_data_in;
    logic        ethernet_rcv_data_rdy_in;
    logic        ethernet_rcv_complete_in;
    logic [47:0] rx_dest_mac;
    logic [47:0] rx_src_mac;
    logic [15:0] rx_ethertype;
    logic [10:0] rx_word_count;
    logic        rx_packet_valid;
    logic        rx_error;
    logic        rx_addr_match;
    logic [15:0] rx_packet_count;
    logic [8:0]  Debug_LEDG;
    logic [1:0]  state_dbg;

    rx_packet_capture dut (
        .Clock                    (Clock),
        .Reset                    (Reset),
        .start_rx                 (start_rx),
        .ethernet_rcv_req_out     (ethernet_rcv_req_out),
        .ethernet_rcv_data_in     (ethernet_rcv_data_in),
        .ethernet_rcv_data_rdy_in (ethernet_rcv_data_rdy_in),
        .ethernet_rcv_complete_in (ethernet_rcv_complete_in),
        .rx_dest_mac              (rx_dest_mac),
        .rx_src_mac               (rx_src_mac),
        .rx_ethertype             (rx_ethertype),
        .rx_word_count            (rx_word_count),
        .rx_packet_valid          (rx_packet_valid),
        .rx_error                 (rx_error),
        .rx_addr_match            (rx_addr_match),
        .rx_packet_count          (rx_packet_count),
        .Debug_LEDG               (Debug_LEDG),
        .state_dbg                (state_dbg)
    );

    // Clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Record: {is_valid, dest, src, ethertype, word_count, addr_match, pkt_count}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;
    logic [W-1:0] mon_e;
    int checks;
    int failures;

    // Reference model of the published outputs
    logic [47:0] m_dest, m_src;
    logic [15:0] m_type, m_cnt;
    logic [10:0] m_wc;
    logic        m_match;

    typedef struct {
        int          n;
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] et;
        int          gap_max;
        bit          same_cycle;
        bit          start_mid;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input int i, input logic [47:0] dest,
                                            input logic [47:0] src, input logic [15:0] et);
        logic [47:0] m;
        int j;
        if (i < 3) begin
            m = dest; j = i;
        end else if (i < 6) begin
            m = src; j = i - 3;
        end else if (i == 6) begin
            return {et[7:0], et[15:8]};
        end else begin
            return 16'($urandom);
        end
        return {m[39-16*j -: 8], m[47-16*j -: 8]};
    endfunction

    task automatic push_expect(input int n, input logic [47:0] dest,
                               input logic [47:0] src, input logic [15:0] et);
        bit ok;
        ok = (n >= 7) && (n <= MAX_W);
        if (ok) begin
            m_dest  = dest;
            m_src   = src;
            m_type  = et;
            m_wc    = 11'(n);
            m_match = (dest == MY_MAC) || (dest == 48'hFFFF_FFFF_FFFF);
            m_cnt   = m_cnt + 16'd1;
        end
        exp_q.push_back({ok, m_dest, m_src, m_type, m_wc, m_match, m_cnt});
    endtask

    // Driver tasks (inputs change on the falling edge)
    task automatic pulse_start();
        start_rx = 1'b1;
        @(negedge Clock);
        start_rx = 1'b0;
        chk("req_after_start", ethernet_rcv_req_out, 1);
        chk("ledg_req", Debug_LEDG[8], 1);
    endtask

    task automatic drive_word(input logic [15:0] w, input bit last, input bit mid_start);
        ethernet_rcv_data_in     = w;
        ethernet_rcv_data_rdy_in = 1'b1;
        ethernet_rcv_complete_in = last;
        start_rx                 = mid_start;
        @(negedge Clock);
        ethernet_rcv_data_rdy_in = 1'b0;
        ethernet_rcv_complete_in = 1'b0;
        start_rx                 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge Clock);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_no_event pending=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
        chk({name, "_req_low"}, ethernet_rcv_req_out, 0);
    endtask

    task automatic send_packet(input vec_t v);
        push_expect(v.n, v.dest, v.src, v.et);
        pulse_start();
        for (int i = 0; i < v.n; i++) begin
            repeat ($urandom_range(0, v.gap_max)) @(negedge Clock);
            drive_word(word_at(i, v.dest, v.src, v.et),
                       v.same_cycle && (i == v.n - 1), v.start_mid && (i == 2));
        end
        if (!v.same_cycle || v.n == 0) begin
            ethernet_rcv_complete_in = 1'b1;
            @(negedge Clock);
            ethernet_rcv_complete_in = 1'b0;
        end
        wait_drain("pkt");
    endtask

    // Scoreboard: pop on each valid/error pulse; outputs must hold otherwise
    always @(negedge Clock) begin
        if (!Reset) begin
            if (rx_packet_valid || rx_error) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse valid=%0b error=%0b expected none",
                             rx_packet_valid, rx_error);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_valid", rx_packet_valid, mon_e[140]);
                    chk("pulse_error", rx_error, !mon_e[140]);
                    chk("dest_mac", rx_dest_mac, mon_e[139:92]);
                    chk("src_mac", rx_src_mac, mon_e[91:44]);
                    chk("ethertype", rx_ethertype, mon_e[43:28]);
                    chk("word_count", rx_word_count, mon_e[27:17]);
                    chk("addr_match", rx_addr_match, mon_e[16]);
                    chk("packet_count", rx_packet_count, mon_e[15:0]);
                    chk("ledg_count", Debug_LEDG[7:0], mon_e[7:0]);
                    cur_exp = mon_e;
                end
            end else begin
                checks++;
                if ({rx_dest_mac, rx_src_mac, rx_ethertype, rx_word_count, rx_addr_match,
                     rx_packet_count} !== cur_exp[139:0]) begin
                    failures++;
                    $display("FAIL outputs_stable actual=%0h expected=%0h",
                             {rx_dest_mac, rx_src_mac, rx_ethertype, rx_word_count,
                              rx_addr_match, rx_packet_count}, cur_exp[139:0]);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({name, "_req"}, ethernet_rcv_req_out, 0);
        chk({name, "_dest"}, rx_dest_mac, 0);
        chk({name, "_src"}, rx_src_mac, 0);
        chk({name, "_type"}, rx_ethertype, 0);
        chk({name, "_wc"}, rx_word_count, 0);
        chk({name, "_valid"}, rx_packet_valid, 0);
        chk({name, "_error"}, rx_error, 0);
        chk({name, "_match"}, rx_addr_match, 0);
        chk({name, "_count"}, rx_packet_count, 0);
        chk({name, "_ledg"}, Debug_LEDG, 0);
        chk({name, "_state"}, state_dbg, 0);
    endtask

    initial begin
        int k;
        checks = 0;
        failures = 0;
        cur_exp = '0;
        m_dest = '0; m_src = '0; m_type = '0; m_wc = '0; m_match = 1'b0; m_cnt = '0;
        Reset = 1'b1;
        start_rx = 1'b0;
        ethernet_rcv_data_in = '0;
        ethernet_rcv_data_rdy_in = 1'b0;
        ethernet_rcv_complete_in = 1'b0;

        vecs[0] = '{30,  48'h0123_4567_89AB, 48'h0A1B_2C3D_4E5F, 16'h0800, 0,  1'b0, 1'b0};
        vecs[1] = '{12,  48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'h0806, 2,  1'b0, 1'b0};
        vecs[2] = '{10,  48'h0000_0000_0001, 48'h6655_4433_2211, 16'h86DD, 10, 1'b0, 1'b0};
        vecs[3] = '{5,   48'h0123_4567_89AB, 48'h0000_0000_0000, 16'h0000, 0,  1'b0, 1'b0};
        vecs[4] = '{7,   48'h0123_4567_89AB, 48'hAABB_CCDD_EEFF, 16'h88B5, 0,  1'b1, 1'b1};
        vecs[5] = '{6,   48'h0123_4567_89AB, 48'h0102_0304_0506, 16'h0800, 1,  1'b0, 1'b0};
        vecs[6] = '{760, 48'h0000_0000_0002, 48'h0203_0405_0607, 16'h0801, 0,  1'b1, 1'b0};
        vecs[7] = '{761, 48'h0123_4567_89AB, 48'h0304_0506_0708, 16'h0802, 0,  1'b0, 1'b0};
        vecs[8] = '{0,   48'h0000_0000_0000, 48'h0000_0000_0000, 16'h0000, 0,  1'b0, 1'b0};
        vecs[9] = '{8,   48'hFFFF_FFFF_FFFF, 48'h0405_0607_0809, 16'h0803, 10, 1'b0, 1'b1};

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge Clock);
        #2 Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Table-driven packets
        foreach (vecs[i]) send_packet(vecs[i]);

        // Timeout after gapped data
        push_expect(3, 48'h0, 48'h0, 16'h0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 10)) @(negedge Clock);
            drive_word(16'($urandom), 1'b0, 1'b0);
        end
        k = 0;
        for (int c = 1; c <= TIMEOUT + 1; c++) begin
            @(negedge Clock);
            if (rx_error) begin
                k = c;
                break;
            end
        end
        chk("timeout_latency", k, TIMEOUT);
        chk("timeout_req_low", ethernet_rcv_req_out, 0);
        wait_drain("timeout");
        send_packet(vecs[0]);

        // Reset in the middle of a packet
        pulse_start();
        for (int i = 0; i < 5; i++) drive_word(word_at(i, MY_MAC, 48'h1, 16'h0800), 1'b0, 1'b0);
        #2 Reset = 1'b1;
        cur_exp = '0;
        m_dest = '0; m_src = '0; m_type = '0; m_wc = '0; m_match = 1'b0; m_cnt = '0;
        #1;
        check_all_zero("midreset");
        @(negedge Clock);
        #2 Reset = 1'b0;
        repeat (5) @(negedge Clock);
        chk("post_reset_req", ethernet_rcv_req_out, 0);
        send_packet(vecs[1]);
        send_packet(vecs[2]);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expect pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
